// File: rtl/regfile_writeback.sv
// Writeback stage: ALU results and queued load results share one register-file
// write port, with a busy-bit scoreboard for decode hazards. Define WB_BYPASS_EN
// to forward the registered write data back to decode.
module regfile_writeback #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [4:0]  query_rs1,
  input  logic [4:0]  query_rs2,
  output logic        stall,
  output logic [4:0]  addr_rd,
  output logic [31:0] data_rd,
  output logic        write_enable,
  output logic        fwd_hit_rs1,
  output logic        fwd_hit_rs2,
  output logic [31:0] fwd_data
);

  localparam int PW = $clog2(LQ_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t   lq_mem [LQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, push, pop;
  wb_entry_t     sel;
  logic          sel_valid;
  logic [31:0]   busy, busy_nxt;

  assign full      = (count == (PW+1)'(LQ_DEPTH));
  assign lsu_ready = !full;
  assign push      = lsu_valid && !full;

  // ALU always wins the write port; the queue only drains on ALU-idle cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel       = '{rd: alu_rd, data: alu_data};
    sel_valid = 1'b0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
    end else if (count != '0) begin
      sel       = lq_mem[rd_ptr];
      sel_valid = 1'b1;
      pop       = 1'b1;
    end
  end

  // NOTE: the queue storage has no reset; a flushed entry is unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push) lq_mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Writes to x0 are consumed silently and leave the last address/data visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enable <= 1'b0;
      addr_rd      <= '0;
      data_rd      <= '0;
    end else begin
      write_enable <= sel_valid && (sel.rd != '0);
      if (sel_valid && (sel.rd != '0)) begin
        addr_rd <= sel.rd;
        data_rd <= sel.data;
      end
    end
  end

  // Clear first, then set, so a new issue to a retiring register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[addr_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit_rs1 = write_enable && (addr_rd == query_rs1) && (query_rs1 != '0);
  assign fwd_hit_rs2 = write_enable && (addr_rd == query_rs2) && (query_rs2 != '0);
  assign fwd_data    = data_rd;
`else
  assign fwd_hit_rs1 = 1'b0;
  assign fwd_hit_rs2 = 1'b0;
  assign fwd_data    = '0;
`endif

  assign stall = (busy[query_rs1] && !fwd_hit_rs1) || (busy[query_rs2] && !fwd_hit_rs2);

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_regfile_writeback;

  localparam int LQ_DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, alu_valid, lsu_valid;
  logic [4:0]  issue_rd, alu_rd, lsu_rd, query_rs1, query_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, stall, write_enable, fwd_hit_rs1, fwd_hit_rs2;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd, fwd_data;

  always #5 clock = ~clock;

  regfile_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .query_rs1(query_rs1), .query_rs2(query_rs2), .stall(stall),
    .addr_rd(addr_rd), .data_rd(data_rd), .write_enable(write_enable),
    .fwd_hit_rs1(fwd_hit_rs1), .fwd_hit_rs2(fwd_hit_rs2), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } load_t;

  load_t       m_q[$];
  bit [31:0]   m_busy;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Compare all outputs mid-cycle, then advance model and DUT across one edge.
  task automatic cycle();
    bit          f1, f2, ready, sel;
    load_t       s;
    bit [31:0]   nb;
    #1;
    f1    = BYP && m_we && (m_addr == query_rs1) && (query_rs1 != 0);
    f2    = BYP && m_we && (m_addr == query_rs2) && (query_rs2 != 0);
    ready = (m_q.size() < LQ_DEPTH);
    check("lsu_ready", lsu_ready, ready);
    check("stall", stall, (m_busy[query_rs1] && !f1) || (m_busy[query_rs2] && !f2));
    check("fwd_hit_rs1", fwd_hit_rs1, f1);
    check("fwd_hit_rs2", fwd_hit_rs2, f2);
    check("fwd_data", fwd_data, BYP ? m_data : 32'h0);
    check("write_enable", write_enable, m_we);
    check("addr_rd", addr_rd, m_addr);
    check("data_rd", data_rd, m_data);
    sel = 1'b0;
    s   = '{rd: 5'd0, data: 32'h0};
    if (alu_valid) begin
      sel = 1'b1;
      s   = '{rd: alu_rd, data: alu_data};
    end else if (m_q.size() > 0) begin
      sel = 1'b1;
      s   = m_q.pop_front();
    end
    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    if (lsu_valid && ready) m_q.push_back('{rd: lsu_rd, data: lsu_data});
    @(posedge clock);
    m_busy = nb;
    m_we   = sel && (s.rd != 0);
    if (m_we) begin
      m_addr = s.rd;
      m_data = s.data;
    end
    @(negedge clock);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_we", write_enable, 1'b0);
    check("rst_addr", addr_rd, 5'd0);
    check("rst_data", data_rd, 32'h0);
    check("rst_ready", lsu_ready, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_fwd", {fwd_hit_rs1, fwd_hit_rs2, fwd_data}, 34'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic idle();
    issue_valid = 0; alu_valid = 0; lsu_valid = 0;
    issue_rd = 0; alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
    query_rs1 = 0; query_rs2 = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    @(negedge clock);
    do_reset();

    // Issue x5, ALU writes it, observe write timing and stall release.
    issue_valid = 1; issue_rd = 5; query_rs1 = 5;
    cycle();
    issue_valid = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    check("alu_we", write_enable, 1'b1);
    check("alu_addr", addr_rd, 5'd5);
    check("alu_data", data_rd, 32'hDEADBEEF);
    alu_valid = 0;
    #1;
    check("stall_write_cycle", stall, BYP ? 1'b0 : 1'b1);
    cycle();
    check("stall_after", stall, 1'b0);

    // ALU and loads contend for 6 cycles; queue fills, then drains with a full+pop cycle.
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 5'(8 + i); alu_data = 32'hA000_0000 + i;
      lsu_valid = 1; lsu_rd = 5'(16 + i); lsu_data = 32'hB000_0000 + i;
      cycle();
    end
    check("full_ready", lsu_ready, 1'b0);
    alu_valid = 0; lsu_rd = 5'd30; lsu_data = 32'hC0FFEE00;
    cycle();
    check("after_pop_ready", lsu_ready, 1'b1);
    check("first_drain", data_rd, 32'hB000_0000);
    cycle();
    lsu_valid = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("last_drain", data_rd, 32'hC0FFEE00);

    // Re-issue x7 on the edge its previous write retires: x7 stays busy.
    issue_valid = 1; issue_rd = 7; query_rs1 = 7; query_rs2 = 0;
    cycle();
    issue_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h7777;
    cycle();
    alu_valid = 0; issue_valid = 1; issue_rd = 7;
    cycle();
    issue_valid = 0;
    #1;
    check("x7_busy_kept", stall, 1'b1);
    cycle();

    // Load to x0 is consumed without a write and never stalls.
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234; query_rs1 = 0; query_rs2 = 0;
    cycle();
    lsu_valid = 0;
    cycle();
    check("x0_no_write", write_enable, 1'b0);
    cycle();

    // Three loads held in the queue behind x0 ALU traffic, then reset mid-flight.
    alu_valid = 1; alu_rd = 0;
    issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      issue_rd = 5'(3 + i);
      lsu_valid = 1; lsu_rd = 5'(3 + i); lsu_data = 32'h5000 + i;
      cycle();
    end
    issue_valid = 0; lsu_valid = 0; alu_valid = 0; query_rs1 = 3; query_rs2 = 4;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_rst_no_write", write_enable, 1'b0);
    end

    // Random traffic with a narrow register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      issue_valid = ($urandom_range(0, 9) < 4);
      issue_rd    = 5'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 9) < 6);
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      query_rs1   = 5'($urandom_range(0, 7));
      query_rs2   = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter LQ_DEPTH, default 4, sets load-result queue depth; power of two, >=2.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 issue_valid  in  1  instruction issued that will write issue_rd.
REQ-005 issue_rd  in  5  destination register of the issued instruction.
REQ-006 alu_valid  in  1  ALU result present this cycle; always accepted.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_data  in  32  ALU result.
REQ-009 lsu_valid  in  1  load result offered.
REQ-010 lsu_ready  out  1  load queue can accept; equals !full.
REQ-011 lsu_rd  in  5  load destination register.
REQ-012 lsu_data  in  32  load data.
REQ-013 query_rs1, query_rs2  in  5 each  source registers of the instruction in decode.
REQ-014 stall  out  1  combinational hazard flag for the decode instruction.
REQ-015 addr_rd  out  5  register-file write address, registered.
REQ-016 data_rd  out  32  register-file write data, registered.
REQ-017 write_enable  out  1  register-file write strobe, registered.
REQ-018 fwd_hit_rs1, fwd_hit_rs2  out  1 each; fwd_data  out  32  bypass outputs.

Function
REQ-019 The load queue SHALL be a FIFO; lsu_valid && lsu_ready pushes {lsu_rd, lsu_data} at the clock edge.
REQ-020 lsu_ready SHALL be low when the queue is full, even if a pop occurs in the same cycle.
REQ-021 Each cycle, the writeback select SHALL use fixed priority: the ALU if alu_valid, else the queue head if the queue is non-empty, else idle.
REQ-022 The selected entry SHALL appear on addr_rd/data_rd with write_enable=1 one cycle later; load latency from push to write is at least 2 cycles.
REQ-023 A queue pop SHALL occur only in a cycle where the queue is selected.
REQ-024 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-025 Queue pointers SHALL wrap modulo LQ_DEPTH.
REQ-026 A selected entry with rd=0 SHALL be consumed with write_enable=0 and addr_rd/data_rd unchanged.
REQ-027 The scoreboard SHALL be a 32-bit busy vector.
REQ-028 A busy bit SHALL be set on the edge where issue_valid=1 and issue_rd!=0.
REQ-029 A busy bit SHALL be cleared on the edge where write_enable=1 for that addr_rd.
REQ-030 When a set and a clear hit the same register on the same edge, the set SHALL win.
REQ-031 busy[0] SHALL always be 0.
REQ-032 stall SHALL equal busy[query_rs1] | busy[query_rs2] (subject to REQ-037).

Reset
REQ-033 reset_n low SHALL immediately clear the busy vector, queue pointers and occupancy; write_enable, addr_rd, data_rd, fwd_hit_rs1, fwd_hit_rs2 and fwd_data SHALL reset to 0 and lsu_ready to 1.
REQ-034 Queue contents SHALL be discarded on reset, including mid-operation.
REQ-035 Reset SHALL suppress any write in flight on the same edge.

Configuration
REQ-036 Macro WB_BYPASS_EN SHALL compile the bypass feature in when defined.
REQ-037 With WB_BYPASS_EN: fwd_hit_rsN SHALL equal write_enable && addr_rd==query_rsN && query_rsN!=0; fwd_data SHALL equal data_rd; stall SHALL ignore a busy source whose fwd_hit is 1.
REQ-038 Without WB_BYPASS_EN: the fwd_* outputs SHALL be tied to 0 and stall follows REQ-032 unchanged.

Verification
REQ-039 issue rd=5; ALU writes x5=0xDEADBEEF -> write_enable=1, addr_rd=5, data_rd=0xDEADBEEF the next cycle; busy[5] clears on that edge; stall with query_rs1=5 drops one cycle later (no bypass) or in the write cycle (bypass).
REQ-040 alu_valid and lsu_valid both held for 6 cycles, LQ_DEPTH=4 -> lsu_ready low after 4 pushes; 6 ALU writes, then 4 loads drain in FIFO order.
REQ-041 Queue full with simultaneous pop -> lsu_ready stays 0; next cycle lsu_ready=1; no entry is lost or duplicated.
REQ-042 issue_valid rd=7 on the same edge a write to x7 retires -> busy[7] remains 1.
REQ-043 Load with rd=0, data=0x1234 -> entry dequeued, write_enable stays 0, stall never asserted for x0.
REQ-044 reset_n pulsed low with 3 queued loads and busy bits set -> no writes follow, busy vector=0, lsu_ready=1.
